// File: rtl/bus_transfer_arbiter.sv
// Round-robin arbiter for the tri-state register bus: grants one requester, then sequences
// src->dst moves; with BUS_ARB_CLR_OP_EN defined, op=1 requests clear the destination instead.
module bus_transfer_arbiter #(
    parameter int NrOfRequesters = 4,
    parameter int NrOfRegs       = 4,
    parameter int IdxBits        = 2
) (
    input  logic                              Clock,
    input  logic                              Reset,
    input  logic [NrOfRequesters-1:0]         req,
    input  logic [NrOfRequesters*IdxBits-1:0] src,
    input  logic [NrOfRequesters*IdxBits-1:0] dst,
    input  logic [NrOfRequesters-1:0]         op,
    output logic [NrOfRequesters-1:0]         ack,
    output logic [NrOfRequesters-1:0]         err,
    output logic [NrOfRegs-1:0]               reg_cs,
    output logic [NrOfRegs-1:0]               reg_ce,
    output logic                              reg_tick,
    output logic [NrOfRegs-1:0]               reg_clr,
    output logic                              busy
);
    // state | meaning
    // IDLE  | bus released, sampling req for the next grant
    // DRIVE | source register drives the bus
    // LOAD  | source still drives; destination captures on the closing edge
    // CLEAR | destination register cleared (clear-op builds only)
    // ACK   | bus turnaround, ack/err pulse to the granted requester

    localparam int GntBits = (NrOfRequesters > 1) ? $clog2(NrOfRequesters) : 1;
    localparam logic [IdxBits:0] RegLimit = (IdxBits+1)'(NrOfRegs);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        LOAD,
`ifdef BUS_ARB_CLR_OP_EN
        CLEAR,
`endif
        ACK
    } state_t;

    state_t                state_q, state_d;
    logic [GntBits-1:0]    last_q, last_d;
    logic [GntBits-1:0]    grant_q, grant_d;
    logic [IdxBits-1:0]    src_q, src_d;
    logic [IdxBits-1:0]    dst_q, dst_d;
    logic                  fault_q, fault_d;

    logic [NrOfRegs-1:0]       reg_cs_q, reg_cs_d;
    logic [NrOfRegs-1:0]       reg_ce_q, reg_ce_d;
    logic                      reg_tick_q, reg_tick_d;
    logic [NrOfRequesters-1:0] ack_q, ack_d;
    logic [NrOfRequesters-1:0] err_q, err_d;
    logic                      busy_q, busy_d;

    logic [IdxBits-1:0]    src_arr [NrOfRequesters];
    logic [IdxBits-1:0]    dst_arr [NrOfRequesters];
    logic [GntBits-1:0]    gnt_sel;
    logic [GntBits-1:0]    cand_idx;
    logic                  gnt_found;
    logic [IdxBits-1:0]    req_src;
    logic [IdxBits-1:0]    req_dst;
    logic                  req_op;

    for (genvar g = 0; g < NrOfRequesters; g++) begin : g_unpack
        assign src_arr[g] = src[g*IdxBits +: IdxBits];
        assign dst_arr[g] = dst[g*IdxBits +: IdxBits];
    end

    // First requesting index after the last grant, wrapping modulo the requester count.
    always_comb begin
        gnt_found = 1'b0;
        gnt_sel   = '0;
        cand_idx  = '0;
        for (int k = 1; k <= NrOfRequesters; k++) begin
            cand_idx = GntBits'((int'(last_q) + k) % NrOfRequesters);
            if (!gnt_found && req[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_sel   = cand_idx;
            end
        end
    end

    assign req_src = src_arr[gnt_sel];
    assign req_dst = dst_arr[gnt_sel];

`ifdef BUS_ARB_CLR_OP_EN
    assign req_op = op[gnt_sel];
`else
    logic unused_op;
    assign unused_op = ^op;
    assign req_op    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        src_d   = src_q;
        dst_d   = dst_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    last_d  = gnt_sel;
                    grant_d = gnt_sel;
                    src_d   = req_src;
                    dst_d   = req_dst;
                    fault_d = ({1'b0, req_src} >= RegLimit) || ({1'b0, req_dst} >= RegLimit)
                              || (!req_op && (req_src == req_dst));
                    if (fault_d) begin
                        state_d = ACK;
`ifdef BUS_ARB_CLR_OP_EN
                    end else if (req_op) begin
                        state_d = CLEAR;
`endif
                    end else begin
                        state_d = DRIVE;
                    end
                end
            end
            DRIVE:   state_d = LOAD;
            LOAD:    state_d = ACK;
`ifdef BUS_ARB_CLR_OP_EN
            CLEAR:   state_d = ACK;
`endif
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every control lands on a flop.
    always_comb begin
        reg_cs_d   = '1;
        reg_ce_d   = '0;
        reg_tick_d = (state_d == LOAD);
        ack_d      = '0;
        err_d      = '0;
        busy_d     = (state_d != IDLE);
        for (int i = 0; i < NrOfRegs; i++) begin
            if ((state_d == DRIVE || state_d == LOAD) && src_d == IdxBits'(i)) begin
                reg_cs_d[i] = 1'b0;
            end
            if (state_d == LOAD && dst_d == IdxBits'(i)) begin
                reg_ce_d[i] = 1'b1;
            end
        end
        for (int j = 0; j < NrOfRequesters; j++) begin
            if (state_d == ACK && grant_d == GntBits'(j)) begin
                ack_d[j] = 1'b1;
                err_d[j] = fault_d;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            last_q     <= GntBits'(NrOfRequesters - 1);
            grant_q    <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            fault_q    <= 1'b0;
            reg_cs_q   <= '1;
            reg_ce_q   <= '0;
            reg_tick_q <= 1'b0;
            ack_q      <= '0;
            err_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            fault_q    <= fault_d;
            reg_cs_q   <= reg_cs_d;
            reg_ce_q   <= reg_ce_d;
            reg_tick_q <= reg_tick_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

`ifdef BUS_ARB_CLR_OP_EN
    logic [NrOfRegs-1:0] reg_clr_q, reg_clr_d;

    always_comb begin
        reg_clr_d = '0;
        for (int i = 0; i < NrOfRegs; i++) begin
            if (state_d == CLEAR && dst_d == IdxBits'(i)) begin
                reg_clr_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            reg_clr_q <= '0;
        end else begin
            reg_clr_q <= reg_clr_d;
        end
    end

    assign reg_clr = reg_clr_q;
`else
    assign reg_clr = '0;
`endif

    assign reg_cs   = reg_cs_q;
    assign reg_ce   = reg_ce_q;
    assign reg_tick = reg_tick_q;
    assign ack      = ack_q;
    assign err      = err_q;
    assign busy     = busy_q;

endmodule
